// File: rtl/cam_frame_writer.sv
// Frame writer: moves a 64-bit pixel stream into memory as fixed-length write
// bursts starting at a programmable base, with one burst outstanding at a time.
module cam_frame_writer #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       frame_bytes,
  input  logic [63:0]       sdata,
  input  logic              sdata_valid,
  input  logic              sdata_burst_valid,
  output logic              sdata_ready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [63:0]       wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned BURST_BYTES = BURST_LEN * 8;
  localparam int unsigned SHIFT       = $clog2(BURST_BYTES);
  localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         bursts_left_q, bursts_left_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [31:0]         start_bursts;
  logic                w_fire;

  // Remainder bytes below one burst are dropped (floor division).
  assign start_bursts = frame_bytes >> SHIFT;

  always_comb begin
    awvalid     = (state_q == ST_ADDR);
    wvalid      = (state_q == ST_DATA) && sdata_valid;
    sdata_ready = wvalid && wready;
    wlast       = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
    bready      = (state_q == ST_RESP);
    w_fire      = wvalid && wready;
  end

  assign awaddr    = addr_q;
  assign awlen     = 4'(BURST_LEN - 1);
  assign wdata     = sdata;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bursts_left_d = bursts_left_q;
    beat_d        = beat_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = base_addr;
          bursts_left_d = start_bursts;
          err_d         = 1'b0;
          if (start_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (sdata_burst_valid) begin
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (awready) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_fire) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            err_d = 1'b1;
          end
          bursts_left_d = bursts_left_q - 32'd1;
          addr_d        = addr_q + ADDR_W'(BURST_BYTES);
          if (bursts_left_q == 32'd1) begin
            done_d      = 1'b1;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      bursts_left_q <= '0;
      beat_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      bursts_left_q <= bursts_left_d;
      beat_q        <= beat_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, beats per write burst; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have a single clock domain: one clock, synchronous active-low reset.
REQ-004 fclk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 start  in  1  one-cycle frame-write request.
REQ-007 base_addr  in  ADDR_W  frame byte base, sampled on accepted start.
REQ-008 frame_bytes  in  32  frame length in bytes, sampled on accepted start; must be a multiple of BURST_LEN*8.
REQ-009 sdata  in  64  pixel stream word.
REQ-010 sdata_valid  in  1  sdata valid.
REQ-011 sdata_burst_valid  in  1  at least BURST_LEN words are available.
REQ-012 sdata_ready  out  1  stream word consumed this cycle.
REQ-013 awaddr  out  ADDR_W  burst address.
REQ-014 awlen  out  4  constant BURST_LEN-1.
REQ-015 awvalid / awready  out / in  1 / 1  address handshake.
REQ-016 wdata  out  64  equals sdata.
REQ-017 wvalid / wready / wlast  out / in / out  1 each  data channel.
REQ-018 bvalid / bresp / bready  in / in 2 / out  1 / 2 / 1  write response.
REQ-019 busy  out  1  frame in progress.
REQ-020 done  out  1  one-cycle pulse at frame end.
REQ-021 err  out  1  sticky error flag.
REQ-022 frame_cnt  out  16  completed frames, wrapping.

Function
REQ-023 States SHALL be IDLE, WAIT, ADDR, DATA, RESP.
REQ-024 IDLE, start=1: SHALL latch addr=base_addr, bursts_left=frame_bytes/(BURST_LEN*8), clear err, set busy, and go to WAIT.
- If frame_bytes=0: go to IDLE instead and pulse done the next cycle; no bursts issued.
REQ-025 start while busy SHALL be ignored, with no side effects.
REQ-026 WAIT: SHALL go to ADDR only when sdata_burst_valid=1; awvalid stays 0 until then.
REQ-027 ADDR: awvalid=1, awaddr=addr, held stable until awready=1; then go to DATA with beat=0.
REQ-028 DATA handshake:
- wvalid=sdata_valid; sdata_ready=wready & sdata_valid.
- A beat transfers when wvalid & wready.
- wlast=1 exactly when beat=BURST_LEN-1.
- beat increments per transfer; after the last transfer go to RESP.
REQ-029 sdata_ready and wvalid SHALL be 0 in every state except DATA.
REQ-030 RESP: bready=1. On bvalid:
- If bresp!=0, set err=1 (sticky).
- Decrement bursts_left and add BURST_LEN*8 to addr.
- If bursts_left was 1: go to IDLE, pulse done, clear busy, increment frame_cnt.
- Otherwise go to WAIT.
REQ-031 An error SHALL NOT abort the frame; all remaining bursts SHALL still be written.
REQ-032 addr SHALL wrap modulo 2^ADDR_W; frame_cnt SHALL wrap from 0xFFFF to 0.
REQ-033 At most one burst SHALL be outstanding at any time.
REQ-034 frame_bytes not a multiple of BURST_LEN*8: the remainder SHALL be truncated (floor); err SHALL NOT be set for this.

Reset
REQ-035 rst_n=0 on a clock edge SHALL force:
- state=IDLE;
- busy, done, err, awvalid, wvalid, wlast, bready, sdata_ready = 0;
- frame_cnt, addr, bursts_left, beat = 0.
This applies mid-burst as well; no pending handshake is completed.
REQ-036 awlen SHALL equal BURST_LEN-1 during and after reset.

Verification
REQ-037 Normal frame, BURST_LEN=16, base=0x1000, frame_bytes=256, stream always valid, slave always ready:
- awaddr 0x1000 then 0x1080;
- 32 beats total, wlast on beats 15 and 31;
- done pulses once; frame_cnt=1; busy low afterwards.
REQ-038 sdata_burst_valid held 0 for 50 cycles after start: awvalid stays 0; first AW issued the cycle after burst_valid rises.
REQ-039 Backpressure: wready toggles every other cycle and sdata_valid has gaps. Required: no beat lost or duplicated, wdata order matches sdata order, and wlast falls on the 16th transfer.
REQ-040 bresp=2 on the first of 2 bursts: err=1, second burst still issued, done pulses; next start clears err.
REQ-041 rst_n low during DATA at beat 7: the next cycle all outputs are at reset values; a new start with base=0x2000 issues awaddr 0x2000.
REQ-042 start asserted during RESP and start with frame_bytes=0: the first is ignored (no restart); the second gives no AW and a done pulse the cycle after start.
